// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8-bit UART transmitter (8N1/8E1/8O1) with a one-entry holding buffer
//
// Ports:
//   clock_i          system clock, all state on the rising edge
//   reset_i          asynchronous active-low reset
//   send_i           send strobe; a 0->1 transition requests one load of data_i
//   data_i[7:0]      byte to transmit, sampled on the accepting edge
//   parity_bit_i     1 = append a parity bit after the data bits
//   parity_even_i    1 = even parity, 0 = odd parity
//   clock_divider_i  bit period in clock_i cycles (0 and 1 both mean 1)
//   serial_o         line output, idle high
//   ready_o          holding buffer empty; sends are accepted only while high
//   busy_o           a frame (start through stop bit) is on the line
module uart_tx (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        send_i,
  input  logic [7:0]  data_i,
  input  logic        parity_bit_i,
  input  logic        parity_even_i,
  input  logic [15:0] clock_divider_i,
  output logic        serial_o,
  output logic        ready_o,
  output logic        busy_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]  state;
  logic        send_q;
  logic [7:0]  buf_data;
  logic        buf_full;
  logic [7:0]  shift;
  logic [2:0]  bit_cnt;
  logic [15:0] cnt;
  logic [15:0] div_q;
  logic        par_en_q;
  logic        par_val_q;

  logic        request;
  logic        accept;
  logic        bit_end;
  logic        transfer;
  logic [15:0] div_sel;

  assign request  = send_i & ~send_q;
  // ready_o is the pre-edge view, so a request on the same edge as a
  // transfer that empties the buffer is still dropped.
  assign accept   = request & ~buf_full;
  assign bit_end  = (cnt == 16'd0);
  assign transfer = buf_full & ((state == S_IDLE) | ((state == S_STOP) & bit_end));
  assign div_sel  = (clock_divider_i == 16'd0) ? 16'd1 : clock_divider_i;

  // send_q resets high so a strobe held through reset release is not a new edge.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      send_q   <= 1'b1;
      buf_data <= 8'd0;
      buf_full <= 1'b0;
    end else begin
      send_q <= send_i;
      if (accept) begin
        buf_data <= data_i;
        buf_full <= 1'b1;
      end else if (transfer) begin
        buf_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state     <= S_IDLE;
      shift     <= 8'd0;
      bit_cnt   <= 3'd0;
      cnt       <= 16'd0;
      div_q     <= 16'd1;
      par_en_q  <= 1'b0;
      par_val_q <= 1'b0;
    end else if (transfer) begin
      // Frame configuration is frozen here for the whole frame.
      state     <= S_START;
      shift     <= buf_data;
      bit_cnt   <= 3'd0;
      cnt       <= div_sel - 16'd1;
      div_q     <= div_sel;
      par_en_q  <= parity_bit_i;
      par_val_q <= (^buf_data) ^ ~parity_even_i;
    end else begin
      case (state)
        S_START: begin
          if (bit_end) begin
            state <= S_DATA;
            cnt   <= div_q - 16'd1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt <= div_q - 16'd1;
            if (bit_cnt == 3'd7) begin
              state <= par_en_q ? S_PARITY : S_STOP;
            end else begin
              shift   <= shift >> 1;
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state <= S_STOP;
            cnt   <= div_q - 16'd1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_STOP: begin
          // A buffered byte is handled by the transfer branch above.
          if (bit_end) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    serial_o = 1'b1;
    case (state)
      S_START:  serial_o = 1'b0;
      S_DATA:   serial_o = shift[0];
      S_PARITY: serial_o = par_val_q;
      default:  serial_o = 1'b1;
    endcase
  end

  assign busy_o  = (state != S_IDLE);
  assign ready_o = ~buf_full;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard testbench for uart_tx
module tb_uart_tx;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        send_i = 1'b0;
  logic [7:0]  data_i = 8'd0;
  logic        parity_bit_i = 1'b0;
  logic        parity_even_i = 1'b0;
  logic [15:0] clock_divider_i = 16'd2;
  logic        serial_o;
  logic        ready_o;
  logic        busy_o;

  uart_tx dut (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .send_i          (send_i),
    .data_i          (data_i),
    .parity_bit_i    (parity_bit_i),
    .parity_even_i   (parity_even_i),
    .clock_divider_i (clock_divider_i),
    .serial_o        (serial_o),
    .ready_o         (ready_o),
    .busy_o          (busy_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic [7:0] data;
    bit         par_en;
    bit         par_bit;
    int         div;
  } exp_t;

  exp_t exp_q[$];
  int   starts[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clock_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_frame(input logic [7:0] d, input bit pe, input bit pb, input int div);
    exp_t e;
    e.data = d; e.par_en = pe; e.par_bit = pb; e.div = div;
    exp_q.push_back(e);
  endtask

  task automatic pulse(input logic [7:0] d);
    data_i = d;
    send_i = 1'b1;
    @(negedge clock_i);
    send_i = 1'b0;
    @(negedge clock_i);
  endtask

  task automatic measure_busy(output int n);
    n = 0;
    while (busy_o === 1'b1 && n < 2000) begin
      n++;
      @(negedge clock_i);
    end
  endtask

  task automatic wait_idle();
    for (int w = 0; w < 2000 && busy_o !== 1'b0; w++) @(negedge clock_i);
    check("wait_idle_busy", busy_o, 0);
    repeat (4) @(negedge clock_i);
  endtask

  // Monitor: decodes frames off the line and compares against the queue.
  initial begin : monitor
    exp_t        e;
    logic [10:0] bits;
    int          nb;
    bit          abort;
    forever begin
      @(negedge clock_i);
      if (!reset_i) begin
        exp_q.delete();
      end else if (serial_o === 1'b0) begin
        starts.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame: got start bit expected idle line (cycle %0d)", cyc);
          for (int w = 0; w < 4000 && busy_o === 1'b1; w++) @(negedge clock_i);
        end else begin
          e = exp_q.pop_front();
          bits = '1;
          bits[0] = 1'b0;
          for (int i = 0; i < 8; i++) bits[i+1] = e.data[i];
          nb = 9;
          if (e.par_en) begin
            bits[9] = e.par_bit;
            nb = 10;
          end
          bits[nb] = 1'b1;
          nb = nb + 1;
          abort = 0;
          for (int b = 0; b < nb && !abort; b++) begin
            for (int k = 0; k < e.div && !abort; k++) begin
              if (b != 0 || k != 0) begin
                @(negedge clock_i);
                if (!reset_i) begin
                  abort = 1;
                  exp_q.delete();
                end
              end
              if (!abort) begin
                check($sformatf("frame_%02h_bit%0d", e.data, b), serial_o, bits[b]);
                check("busy_in_frame", busy_o, 1);
              end
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int n;
    int s0;
    repeat (3) @(negedge clock_i);
    check("reset_serial", serial_o, 1);
    check("reset_busy", busy_o, 0);
    check("reset_ready", ready_o, 1);
    reset_i = 1'b1;
    @(negedge clock_i);

    // Basic 8N1 frame, divider 2
    expect_frame(8'h55, 0, 0, 2);
    data_i = 8'h55;
    send_i = 1'b1;
    @(negedge clock_i);
    check("accept_ready_low", ready_o, 0);
    send_i = 1'b0;
    @(negedge clock_i);
    check("xfer_ready_high", ready_o, 1);
    check("xfer_busy_high", busy_o, 1);
    check("xfer_start_bit", serial_o, 0);
    measure_busy(n);
    check("busy_len_8n1", n, 20);
    wait_idle();

    // Even parity on 0xA7 (five ones) -> parity bit 1
    parity_bit_i = 1'b1;
    parity_even_i = 1'b1;
    expect_frame(8'hA7, 1, 1, 2);
    pulse(8'hA7);
    measure_busy(n);
    check("busy_len_even", n, 22);
    wait_idle();

    // Odd parity -> parity bit 0
    parity_even_i = 1'b0;
    expect_frame(8'hA7, 1, 0, 2);
    pulse(8'hA7);
    measure_busy(n);
    check("busy_len_odd", n, 22);
    parity_bit_i = 1'b0;
    wait_idle();

    // Buffering and overflow: 0x33 must be dropped
    expect_frame(8'hAA, 0, 0, 2);
    expect_frame(8'hCC, 0, 0, 2);
    s0 = starts.size();
    pulse(8'hAA);
    pulse(8'hCC);
    check("buffered_ready_low", ready_o, 0);
    pulse(8'h33);
    check("overflow_ready_low", ready_o, 0);
    wait_idle();
    check("b2b_frame_count", starts.size() - s0, 2);
    if (starts.size() - s0 == 2) check("b2b_gap", starts[s0+1] - starts[s0], 20);

    // One-shot: level held high loads once
    s0 = starts.size();
    expect_frame(8'h0F, 0, 0, 2);
    data_i = 8'h0F;
    send_i = 1'b1;
    repeat (60) @(negedge clock_i);
    check("oneshot_single", starts.size() - s0, 1);
    send_i = 1'b0;
    @(negedge clock_i);
    expect_frame(8'h0F, 0, 0, 2);
    send_i = 1'b1;
    repeat (30) @(negedge clock_i);
    send_i = 1'b0;
    check("oneshot_second", starts.size() - s0, 2);
    wait_idle();

    // Divider 0 and 1 both mean one cycle per bit
    clock_divider_i = 16'd0;
    expect_frame(8'h81, 0, 0, 1);
    pulse(8'h81);
    measure_busy(n);
    check("busy_len_div0", n, 10);
    wait_idle();
    clock_divider_i = 16'd1;
    expect_frame(8'h7E, 0, 0, 1);
    pulse(8'h7E);
    measure_busy(n);
    check("busy_len_div1", n, 10);
    wait_idle();

    // Divider change mid-frame takes effect on the next frame
    clock_divider_i = 16'd2;
    s0 = starts.size();
    expect_frame(8'h96, 0, 0, 2);
    expect_frame(8'h69, 0, 0, 4);
    pulse(8'h96);
    clock_divider_i = 16'd4;
    pulse(8'h69);
    wait_idle();
    check("divchg_frame_count", starts.size() - s0, 2);
    if (starts.size() - s0 == 2) check("divchg_gap", starts[s0+1] - starts[s0], 20);
    clock_divider_i = 16'd2;

    // Reset mid-frame with a byte buffered
    expect_frame(8'h3C, 0, 0, 2);
    expect_frame(8'h5A, 0, 0, 2);
    pulse(8'h3C);
    pulse(8'h5A);
    repeat (3) @(negedge clock_i);
    check("pre_reset_busy", busy_o, 1);
    #2 reset_i = 1'b0;
    #1;
    check("async_reset_serial", serial_o, 1);
    check("async_reset_busy", busy_o, 0);
    check("async_reset_ready", ready_o, 1);
    repeat (3) @(negedge clock_i);
    reset_i = 1'b1;
    s0 = starts.size();
    repeat (40) @(negedge clock_i);
    check("post_reset_no_frame", starts.size() - s0, 0);
    check("post_reset_busy", busy_o, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
